// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display fetch port and the CPU port.
// Display reads have priority; a starvation counter forces a CPU slot after STARVE_LIMIT
// consecutive display grants while the CPU is waiting.
//
// state  | meaning
// IDLE   | sample requests, pick a winner, latch its address/data
// ACCESS | mem_en strobe for one cycle
// WAIT   | count down the read latency, capture mem_rdata on terminal count
// RESP   | one-cycle ready/ack pulse to the granted port
// GAP    | dead cycle so a requester's registered deassert never triggers a second access
module vram_arbiter #(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_vga_clk,
  input  logic        i_reset,
  input  logic        i_disp_req,
  input  logic [14:0] i_disp_addr,
  output logic [31:0] o_disp_data,
  output logic        o_disp_ready,
  input  logic        i_cpu_req,
  input  logic        i_cpu_write,
  input  logic [14:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [14:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_starve;
  logic [1:0]  r_lat;
  logic        r_sel_cpu;
  logic        r_we;
  logic [31:0] r_disp_data;
  logic        r_disp_ready;
  logic [31:0] r_cpu_rdata;
  logic        r_cpu_ack;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [14:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic w_starved;
  logic w_grant_cpu;
  logic w_grant_disp;

  // Arbitration: display wins unless the CPU has been passed over STARVE_LIMIT times.
  assign w_starved    = (r_starve >= 4'(STARVE_LIMIT));
  assign w_grant_cpu  = i_cpu_req && (!i_disp_req || w_starved);
  assign w_grant_disp = i_disp_req && !w_grant_cpu;

  // Access sequencer with registered memory strobes and completion pulses.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_starve     <= 4'd0;
      r_lat        <= 2'd0;
      r_sel_cpu    <= 1'b0;
      r_we         <= 1'b0;
      r_disp_data  <= 32'd0;
      r_disp_ready <= 1'b0;
      r_cpu_rdata  <= 32'd0;
      r_cpu_ack    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 15'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_disp_ready <= 1'b0;
      r_cpu_ack    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_cpu_req) r_starve <= 4'd0;
          if (w_grant_cpu) begin
            r_sel_cpu   <= 1'b1;
            r_we        <= i_cpu_write;
            r_mem_addr  <= i_cpu_addr;
            r_mem_wdata <= i_cpu_wdata;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_cpu_write;
            r_starve    <= 4'd0;
            r_state     <= S_ACCESS;
          end else if (w_grant_disp) begin
            r_sel_cpu  <= 1'b0;
            r_we       <= 1'b0;
            r_mem_addr <= i_disp_addr;
            r_mem_en   <= 1'b1;
            if (i_cpu_req && (r_starve != 4'hF)) r_starve <= r_starve + 4'd1;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            // Only the CPU can write, so the ack goes straight out.
            r_cpu_ack <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_lat   <= 2'(RD_LAT - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat == 2'd0) begin
            if (r_sel_cpu) begin
              r_cpu_rdata <= i_mem_rdata;
              r_cpu_ack   <= 1'b1;
            end else begin
              r_disp_data  <= i_mem_rdata;
              r_disp_ready <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        S_RESP:  r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_disp_data  = r_disp_data;
  assign o_disp_ready = r_disp_ready;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_ack    = r_cpu_ack;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter: instance A (RD_LAT=1) and instance B (RD_LAT=3),
// each with its own behavioural VRAM that returns junk outside the valid read cycle.
module tb_vram_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_disp_req = 0, a_cpu_req = 0, a_cpu_write = 0;
  logic [14:0] a_disp_addr = '0, a_cpu_addr = '0;
  logic [31:0] a_cpu_wdata = '0;
  logic [31:0] a_disp_data, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_disp_ready, a_cpu_ack, a_mem_en, a_mem_we;
  logic [14:0] a_mem_addr;

  logic        b_disp_req = 0, b_cpu_req = 0, b_cpu_write = 0;
  logic [14:0] b_disp_addr = '0, b_cpu_addr = '0;
  logic [31:0] b_cpu_wdata = '0;
  logic [31:0] b_disp_data, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_disp_ready, b_cpu_ack, b_mem_en, b_mem_we;
  logic [14:0] b_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  vram_arbiter #(.RD_LAT(1), .STARVE_LIMIT(4)) dut_a (
    .i_vga_clk(clk), .i_reset(rst),
    .i_disp_req(a_disp_req), .i_disp_addr(a_disp_addr),
    .o_disp_data(a_disp_data), .o_disp_ready(a_disp_ready),
    .i_cpu_req(a_cpu_req), .i_cpu_write(a_cpu_write), .i_cpu_addr(a_cpu_addr),
    .i_cpu_wdata(a_cpu_wdata), .o_cpu_rdata(a_cpu_rdata), .o_cpu_ack(a_cpu_ack),
    .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata)
  );

  vram_arbiter #(.RD_LAT(3), .STARVE_LIMIT(4)) dut_b (
    .i_vga_clk(clk), .i_reset(rst),
    .i_disp_req(b_disp_req), .i_disp_addr(b_disp_addr),
    .o_disp_data(b_disp_data), .o_disp_ready(b_disp_ready),
    .i_cpu_req(b_cpu_req), .i_cpu_write(b_cpu_write), .i_cpu_addr(b_cpu_addr),
    .i_cpu_wdata(b_cpu_wdata), .o_cpu_rdata(b_cpu_rdata), .o_cpu_ack(b_cpu_ack),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata)
  );

  // VRAM models: contents preloaded on reset, read data valid only RD_LAT cycles after mem_en.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'h1000_0000 | 32'(i);
      mem_a[8'h23] <= 32'hDEAD_BEEF;
      mem_a[8'h10] <= 32'hCAFE_F00D;
      mem_a[8'h42] <= 32'h1234_5678;
      mem_a[8'h20] <= 32'h2020_2020;
      pipe_a <= JUNK;
    end else begin
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:0]] : JUNK;
    end
  end
  assign a_mem_rdata = pipe_a;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'h2000_0000 | 32'(i);
      mem_b[8'h55] <= 32'h600D_CAFE;
      pipe_b[0] <= JUNK;
      pipe_b[1] <= JUNK;
      pipe_b[2] <= JUNK;
    end else begin
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
      pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : JUNK;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end
  assign b_mem_rdata = pipe_b[2];

  // Pulse counters for instance A.
  int n_en_a = 0, n_rdy_a = 0, n_ack_a = 0;
  always @(posedge clk) begin
    if (a_mem_en)     n_en_a  <= n_en_a + 1;
    if (a_disp_ready) n_rdy_a <= n_rdy_a + 1;
    if (a_cpu_ack)    n_ack_a <= n_ack_a + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if ({a_disp_data, a_disp_ready, a_cpu_rdata, a_cpu_ack, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs not zero, disp_data=%h cpu_rdata=%h mem_en=%b mem_addr=%h", a_disp_data, a_cpu_rdata, a_mem_en, a_mem_addr);
    end
    n_tests++;
    if ({b_disp_data, b_disp_ready, b_cpu_rdata, b_cpu_ack, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs not zero, disp_data=%h cpu_rdata=%h mem_en=%b", b_disp_data, b_cpu_rdata, b_mem_en);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_disp_read();
    int en0, rdy0, ack0;
    en0 = n_en_a; rdy0 = n_rdy_a; ack0 = n_ack_a;
    a_disp_addr = 15'h0123; a_disp_req = 1'b1;
    tick();
    n_tests++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_disp_ready} !== {1'b1, 1'b0, 15'h0123, 1'b0}) begin
      n_fail++; $display("FAIL disp_read_access: en=%b we=%b addr=%h rdy=%b, want 1 0 0123 0", a_mem_en, a_mem_we, a_mem_addr, a_disp_ready);
    end
    tick();
    n_tests++;
    if ({a_mem_en, a_disp_ready} !== 2'b00) begin
      n_fail++; $display("FAIL disp_read_wait: en=%b rdy=%b, want 0 0", a_mem_en, a_disp_ready);
    end
    tick();
    n_tests++;
    if (a_disp_ready !== 1'b1 || a_disp_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL disp_read_ready: rdy=%b data=%h, want 1 deadbeef", a_disp_ready, a_disp_data);
    end
    a_disp_req = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (n_en_a - en0 != 1 || n_rdy_a - rdy0 != 1 || n_ack_a - ack0 != 0) begin
      n_fail++; $display("FAIL disp_read_once: accesses=%0d readies=%0d acks=%0d, want 1 1 0", n_en_a - en0, n_rdy_a - rdy0, n_ack_a - ack0);
    end
  endtask

  task automatic test_cpu_write();
    int en0, rdy0, ack0;
    en0 = n_en_a; rdy0 = n_rdy_a; ack0 = n_ack_a;
    a_cpu_write = 1'b1; a_cpu_addr = 15'h7FFF; a_cpu_wdata = 32'hA5A5_A5A5; a_cpu_req = 1'b1;
    tick();
    n_tests++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_ack} !== {1'b1, 1'b1, 15'h7FFF, 32'hA5A5_A5A5, 1'b0}) begin
      n_fail++; $display("FAIL cpu_write_access: en=%b we=%b addr=%h wdata=%h ack=%b, want 1 1 7fff a5a5a5a5 0", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_ack);
    end
    tick();
    n_tests++;
    if (a_cpu_ack !== 1'b1 || a_disp_ready !== 1'b0 || a_mem_we !== 1'b0) begin
      n_fail++; $display("FAIL cpu_write_ack: ack=%b rdy=%b we=%b, want 1 0 0", a_cpu_ack, a_disp_ready, a_mem_we);
    end
    a_cpu_req = 1'b0; a_cpu_write = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (mem_a[8'hFF] !== 32'hA5A5_A5A5 || n_en_a - en0 != 1 || n_ack_a - ack0 != 1 || n_rdy_a - rdy0 != 0) begin
      n_fail++; $display("FAIL cpu_write_once: mem=%h accesses=%0d acks=%0d readies=%0d, want a5a5a5a5 1 1 0", mem_a[8'hFF], n_en_a - en0, n_ack_a - ack0, n_rdy_a - rdy0);
    end
  endtask

  task automatic test_simultaneous();
    a_disp_addr = 15'h0010; a_disp_req = 1'b1;
    a_cpu_write = 1'b0; a_cpu_addr = 15'h0042; a_cpu_req = 1'b1;
    tick();
    n_tests++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 15'h0010) begin
      n_fail++; $display("FAIL simul_disp_first: en=%b addr=%h, want 1 0010", a_mem_en, a_mem_addr);
    end
    tick(); tick();
    n_tests++;
    if (a_disp_ready !== 1'b1 || a_disp_data !== 32'hCAFE_F00D || a_cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL simul_disp_ready: rdy=%b data=%h ack=%b, want 1 cafef00d 0", a_disp_ready, a_disp_data, a_cpu_ack);
    end
    a_disp_req = 1'b0;
    tick();
    n_tests++;
    if (a_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL simul_gap: en=%b, want 0", a_mem_en);
    end
    tick();
    n_tests++;
    if (a_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL simul_idle: en=%b, want 0", a_mem_en);
    end
    tick();
    n_tests++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 15'h0042 || a_mem_we !== 1'b0) begin
      n_fail++; $display("FAIL simul_cpu_access: en=%b addr=%h we=%b, want 1 0042 0", a_mem_en, a_mem_addr, a_mem_we);
    end
    tick(); tick();
    n_tests++;
    if (a_cpu_ack !== 1'b1 || a_cpu_rdata !== 32'h1234_5678 || a_disp_ready !== 1'b0) begin
      n_fail++; $display("FAIL simul_cpu_ack: ack=%b rdata=%h rdy=%b, want 1 12345678 0", a_cpu_ack, a_cpu_rdata, a_disp_ready);
    end
    a_cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_starvation();
    int grants;
    int cyc;
    logic [9:0] pattern;
    grants = 0; cyc = 0; pattern = '0;
    a_disp_addr = 15'h0020; a_disp_req = 1'b1;
    a_cpu_write = 1'b0; a_cpu_addr = 15'h0030; a_cpu_req = 1'b1;
    while (grants < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (a_mem_en) begin
        pattern[grants] = (a_mem_addr == 15'h0030);
        grants++;
      end
    end
    n_tests++;
    if (grants != 10) begin
      n_fail++; $display("FAIL starve_timeout: grants=%0d within %0d cycles, want 10", grants, cyc);
    end
    n_tests++;
    if (pattern !== 10'b10000_10000) begin
      n_fail++; $display("FAIL starve_pattern: grant order (1=cpu, lsb first)=%b, want 1000010000", pattern);
    end
    a_disp_req = 1'b0; a_cpu_req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_rd_lat3();
    b_cpu_write = 1'b0; b_cpu_addr = 15'h0055; b_cpu_req = 1'b1;
    tick();
    n_tests++;
    if (b_mem_en !== 1'b1 || b_mem_addr !== 15'h0055) begin
      n_fail++; $display("FAIL lat3_access: en=%b addr=%h, want 1 0055", b_mem_en, b_mem_addr);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_tests++;
      if (b_cpu_ack !== 1'b0) begin
        n_fail++; $display("FAIL lat3_early_ack: ack=%b at T+%0d, want 0", b_cpu_ack, k);
      end
    end
    tick();
    n_tests++;
    if (b_cpu_ack !== 1'b1 || b_cpu_rdata !== 32'h600D_CAFE) begin
      n_fail++; $display("FAIL lat3_ack: ack=%b rdata=%h at T+5, want 1 600dcafe", b_cpu_ack, b_cpu_rdata);
    end
    b_cpu_req = 1'b0;
    tick();
    n_tests++;
    if (b_cpu_ack !== 1'b0 || b_cpu_rdata !== 32'h600D_CAFE) begin
      n_fail++; $display("FAIL lat3_hold: ack=%b rdata=%h, want 0 600dcafe", b_cpu_ack, b_cpu_rdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int rdy0, ack0;
    a_disp_addr = 15'h0123; a_disp_req = 1'b1;
    tick(); tick();
    n_tests++;
    if (a_mem_en !== 1'b0 || a_disp_ready !== 1'b0 || a_disp_data !== 32'h2020_2020) begin
      n_fail++; $display("FAIL rstmid_pre: en=%b rdy=%b data=%h, want 0 0 20202020", a_mem_en, a_disp_ready, a_disp_data);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_disp_data, a_disp_ready, a_cpu_rdata, a_cpu_ack, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
      n_fail++; $display("FAIL rstmid_zero: disp_data=%h cpu_rdata=%h mem_addr=%h mem_wdata=%h, want all 0", a_disp_data, a_cpu_rdata, a_mem_addr, a_mem_wdata);
    end
    rdy0 = n_rdy_a; ack0 = n_ack_a;
    a_disp_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (n_rdy_a - rdy0 != 0 || n_ack_a - ack0 != 0) begin
      n_fail++; $display("FAIL rstmid_no_resp: readies=%0d acks=%0d after reset, want 0 0", n_rdy_a - rdy0, n_ack_a - ack0);
    end
    a_disp_addr = 15'h0042; a_disp_req = 1'b1;
    tick();
    n_tests++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 15'h0042) begin
      n_fail++; $display("FAIL rstmid_new_access: en=%b addr=%h, want 1 0042", a_mem_en, a_mem_addr);
    end
    tick(); tick();
    n_tests++;
    if (a_disp_ready !== 1'b1 || a_disp_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rstmid_new_ready: rdy=%b data=%h, want 1 12345678", a_disp_ready, a_disp_data);
    end
    a_disp_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_disp_read();
    test_cpu_write();
    test_simultaneous();
    test_starvation();
    test_rd_lat3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
